// File: rtl/cpu_pkg.sv
// Shared CPU register-file types: address/data widths and the write-request record.
// No logic of its own; the helper builds a one-hot register mask.
// Imported by the write-side arbiter and its FIFO.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  // One register-file write: enable, destination, value
  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

  // One-hot mask selecting register 'a' in a NUM_REGS-wide vector
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
    logic [NUM_REGS-1:0] m;
    m    = '0;
    m[a] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding long-latency write results until the write port is free.
// Latency: an entry pushed at edge N is visible at the head (and poppable) from edge N+1.
// Backpressure: full_o blocks pushes; a push while full or a pop while empty is ignored.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = REG_ADDR_W + REG_DATA_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_dat_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         push_ok;
  logic         pop_ok;

  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok    = push_i & ~full_o;
  assign pop_ok     = pop_i & ~empty_o;
  assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];

  // Advance pointers; natural wrap gives modulo-DEPTH addressing
  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);
  end

  // Pointer state; reset empties the queue and abandons stored contents
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset: entries are only read once written
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Merges the WB stage and the long-latency unit onto the register file's single write port,
//   and tracks registers still awaiting a long-latency result. Latency: 1 edge pipe->port,
//   2 edges LU accept->port. Backpressure: lu_ready_o=!full; wb_hold_o asks WB to idle a cycle.
module reg_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  pipe_we_i,
  input  logic [REG_ADDR_W-1:0] pipe_addr_i,
  input  logic [REG_DATA_W-1:0] pipe_data_i,
  input  logic                  lu_valid_i,
  input  logic [REG_ADDR_W-1:0] lu_addr_i,
  input  logic [REG_DATA_W-1:0] lu_data_i,
  output logic                  lu_ready_o,
  input  logic                  rsv_i,
  input  logic [REG_ADDR_W-1:0] rsv_addr_i,
  input  logic [REG_ADDR_W-1:0] chk_rs_addr_i,
  input  logic [REG_ADDR_W-1:0] chk_rt_addr_i,
  output logic                  busy_o,
  output logic                  wb_hold_o,
  output logic                  waw_err_o,
  output logic                  RegWrite_o,
  output logic [REG_ADDR_W-1:0] RDaddr_o,
  output logic [REG_DATA_W-1:0] RDdata_o
);

  localparam int ENT_W = REG_ADDR_W + REG_DATA_W;
  localparam int CNT_W = $clog2(STARVE_MAX + 1) + 1;

  wb_req_t               out_q, out_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic [CNT_W-1:0]      starve_q, starve_d;
  logic                  hold_q, hold_d;
  logic                  waw_q, waw_d;

  logic                  pipe_slot_busy;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic                  lu_push;
  logic [ENT_W-1:0]      fifo_head;
  logic [REG_ADDR_W-1:0] head_addr;
  logic [REG_DATA_W-1:0] head_data;

  assign pipe_slot_busy = pipe_we_i & (pipe_addr_i != '0);
  assign lu_ready_o     = ~fifo_full;
  assign lu_push        = lu_valid_i & ~fifo_full;
  // The FIFO drains whenever WB leaves the port free, including r0 entries that are dropped
  assign fifo_pop       = ~pipe_slot_busy & ~fifo_empty;
  assign head_addr      = fifo_head[ENT_W-1 -: REG_ADDR_W];
  assign head_data      = fifo_head[REG_DATA_W-1:0];

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (lu_push),
    .push_dat_i ({lu_addr_i, lu_data_i}),
    .pop_i      (fifo_pop),
    .head_dat_o (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // Port arbitration: WB first, then FIFO head; otherwise drop enable and hold addr/data
  always_comb begin
    out_d    = out_q;
    out_d.we = 1'b0;
    if (pipe_slot_busy) begin
      out_d.we   = 1'b1;
      out_d.addr = pipe_addr_i;
      out_d.data = pipe_data_i;
    end else if (fifo_pop && (head_addr != '0)) begin
      out_d.we   = 1'b1;
      out_d.addr = head_addr;
      out_d.data = head_data;
    end
  end

  // Pending-write scoreboard: a pop clears its register, a reservation at the same edge wins
  always_comb begin
    busy_d = busy_q;
    if (fifo_pop && (head_addr != '0)) busy_d = busy_d & ~reg_onehot(head_addr);
    if (rsv_i && (rsv_addr_i != '0))   busy_d = busy_d | reg_onehot(rsv_addr_i);
    waw_d = waw_q | (pipe_slot_busy & busy_q[pipe_addr_i]);
  end

  // Starvation: count cycles the head is blocked by WB; request one idle WB cycle at the limit
  always_comb begin
    starve_d = starve_q;
    if (fifo_pop) begin
      starve_d = '0;
    end else if (!fifo_empty && pipe_slot_busy && (starve_q != '1)) begin
      starve_d = starve_q + 1'b1;
    end
    hold_d = (starve_d == CNT_W'(STARVE_MAX)) && (starve_q != CNT_W'(STARVE_MAX));
  end

  // All arbiter state; async active-low reset
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      out_q    <= '0;
      busy_q   <= '0;
      starve_q <= '0;
      hold_q   <= 1'b0;
      waw_q    <= 1'b0;
    end else begin
      out_q    <= out_d;
      busy_q   <= busy_d;
      starve_q <= starve_d;
      hold_q   <= hold_d;
      waw_q    <= waw_d;
    end
  end

  assign busy_o     = ((chk_rs_addr_i != '0) & busy_q[chk_rs_addr_i]) |
                      ((chk_rt_addr_i != '0) & busy_q[chk_rt_addr_i]);
  assign wb_hold_o  = hold_q;
  assign waw_err_o  = waw_q;
  assign RegWrite_o = out_q.we;
  assign RDaddr_o   = out_q.addr;
  assign RDdata_o   = out_q.data;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed stimulus queues expected register-file writes,
// an independent monitor checks every RegWrite_o cycle against that queue,
// and direct checks cover flags, handshake and reset behaviour.
module tb_reg_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        pipe_we_i;
  logic [4:0]  pipe_addr_i;
  logic [31:0] pipe_data_i;
  logic        lu_valid_i;
  logic [4:0]  lu_addr_i;
  logic [31:0] lu_data_i;
  logic        lu_ready_o;
  logic        rsv_i;
  logic [4:0]  rsv_addr_i;
  logic [4:0]  chk_rs_addr_i;
  logic [4:0]  chk_rt_addr_i;
  logic        busy_o;
  logic        wb_hold_o;
  logic        waw_err_o;
  logic        RegWrite_o;
  logic [4:0]  RDaddr_o;
  logic [31:0] RDdata_o;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  reg_wb_arbiter #(.FIFO_DEPTH(2), .STARVE_MAX(4)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .pipe_we_i     (pipe_we_i),
    .pipe_addr_i   (pipe_addr_i),
    .pipe_data_i   (pipe_data_i),
    .lu_valid_i    (lu_valid_i),
    .lu_addr_i     (lu_addr_i),
    .lu_data_i     (lu_data_i),
    .lu_ready_o    (lu_ready_o),
    .rsv_i         (rsv_i),
    .rsv_addr_i    (rsv_addr_i),
    .chk_rs_addr_i (chk_rs_addr_i),
    .chk_rt_addr_i (chk_rt_addr_i),
    .busy_o        (busy_o),
    .wb_hold_o     (wb_hold_o),
    .waw_err_o     (waw_err_o),
    .RegWrite_o    (RegWrite_o),
    .RDaddr_o      (RDaddr_o),
    .RDdata_o      (RDdata_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: every write presented to the register file must be the next expected one
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_i === 1'b1 && RegWrite_o === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write: got r%0d=0x%0h, expected no write", RDaddr_o, RDdata_o);
        end else begin
          e = exp_q.pop_front();
          if (RDaddr_o !== e.a || RDdata_o !== e.d) begin
            n_err++;
            $display("FAIL write_order: got r%0d=0x%0h, expected r%0d=0x%0h",
                     RDaddr_o, RDdata_o, e.a, e.d);
          end
        end
      end
    end
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b0;
    pipe_we_i = 1'b0; pipe_addr_i = '0; pipe_data_i = '0;
    lu_valid_i = 1'b0; lu_addr_i = '0; lu_data_i = '0;
    rsv_i = 1'b0; rsv_addr_i = '0;
    chk_rs_addr_i = '0; chk_rt_addr_i = '0;
    step(); step();

    // Reset state
    check("rst_regwrite", RegWrite_o, 0);
    check("rst_rdaddr",   RDaddr_o,   0);
    check("rst_rddata",   RDdata_o,   0);
    check("rst_lu_ready", lu_ready_o, 1);
    check("rst_busy",     busy_o,     0);
    check("rst_hold",     wb_hold_o,  0);
    check("rst_waw",      waw_err_o,  0);
    rst_i = 1'b1;
    step();

    // Pipe-only write, then a write to r0 which must not reach the port
    pipe_we_i = 1'b1; pipe_addr_i = 5'd3; pipe_data_i = 32'h1234;
    expect_wr(5'd3, 32'h1234);
    step();
    pipe_addr_i = 5'd0; pipe_data_i = 32'h5555;
    step();
    check("pipe_r0_no_write", RegWrite_o, 0);
    check("pipe_r0_addr_hold", RDaddr_o, 3);
    check("pipe_r0_data_hold", RDdata_o, 32'h1234);
    pipe_we_i = 1'b0; pipe_addr_i = '0;

    // LU path with scoreboard on r7
    rsv_i = 1'b1; rsv_addr_i = 5'd7;
    step();
    rsv_i = 1'b0; chk_rs_addr_i = 5'd7;
    #1 check("busy_r7_reserved", busy_o, 1);
    lu_valid_i = 1'b1; lu_addr_i = 5'd7; lu_data_i = 32'hDEAD;
    expect_wr(5'd7, 32'hDEAD);
    step();
    lu_valid_i = 1'b0;
    check("busy_r7_after_accept", busy_o, 1);
    check("lu_no_write_yet", RegWrite_o, 0);
    step();
    check("busy_r7_after_pop", busy_o, 0);
    check("lu_ready_after_pop", lu_ready_o, 1);
    chk_rs_addr_i = '0;

    // Full FIFO while WB writes every cycle; third LU result waits for the first pop
    pipe_we_i = 1'b1; pipe_addr_i = 5'd10; pipe_data_i = 32'hA0;
    lu_valid_i = 1'b1; lu_addr_i = 5'd11; lu_data_i = 32'hB1;
    expect_wr(5'd10, 32'hA0);
    step();
    pipe_data_i = 32'hA1; lu_addr_i = 5'd12; lu_data_i = 32'hB2;
    expect_wr(5'd10, 32'hA1);
    step();
    check("full_ready_low", lu_ready_o, 0);
    pipe_data_i = 32'hA2; lu_addr_i = 5'd13; lu_data_i = 32'hB3;
    expect_wr(5'd10, 32'hA2);
    step();
    check("full_ready_still_low", lu_ready_o, 0);
    pipe_we_i = 1'b0;
    expect_wr(5'd11, 32'hB1);
    step();
    check("ready_after_first_pop", lu_ready_o, 1);
    expect_wr(5'd12, 32'hB2);
    step();
    lu_valid_i = 1'b0;
    expect_wr(5'd13, 32'hB3);
    step();
    check("drained_ready", lu_ready_o, 1);
    step();

    // Starvation: head blocked by r1..r4, hold after the fourth blocked cycle
    pipe_we_i = 1'b1; pipe_addr_i = 5'd6; pipe_data_i = 32'd6;
    lu_valid_i = 1'b1; lu_addr_i = 5'd20; lu_data_i = 32'hC0;
    expect_wr(5'd6, 32'd6);
    step();
    lu_valid_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      pipe_addr_i = 5'(i); pipe_data_i = 32'(i);
      expect_wr(5'(i), 32'(i));
      step();
      check($sformatf("starve_hold_%0d", i), wb_hold_o, (i == 4) ? 32'd1 : 32'd0);
    end
    pipe_we_i = 1'b0;
    expect_wr(5'd20, 32'hC0);
    step();
    check("starve_hold_cleared", wb_hold_o, 0);
    step();

    // WAW on a reserved register is sticky
    rsv_i = 1'b1; rsv_addr_i = 5'd9;
    step();
    rsv_i = 1'b0;
    pipe_we_i = 1'b1; pipe_addr_i = 5'd9; pipe_data_i = 32'h99;
    expect_wr(5'd9, 32'h99);
    step();
    pipe_we_i = 1'b0;
    check("waw_set", waw_err_o, 1);
    step(); step();
    check("waw_sticky", waw_err_o, 1);
    chk_rs_addr_i = 5'd9;
    #1 check("busy_r9_kept", busy_o, 1);
    chk_rs_addr_i = '0;

    // LU entry for r0 drains without a register-file write
    lu_valid_i = 1'b1; lu_addr_i = 5'd0; lu_data_i = 32'hFF;
    step();
    lu_valid_i = 1'b0;
    step();
    check("lu_r0_no_write", RegWrite_o, 0);

    // Reservation coincident with the pop of the same register: set wins
    lu_valid_i = 1'b1; lu_addr_i = 5'd14; lu_data_i = 32'hE0;
    expect_wr(5'd14, 32'hE0);
    step();
    lu_valid_i = 1'b0;
    rsv_i = 1'b1; rsv_addr_i = 5'd14;
    step();
    rsv_i = 1'b0;
    chk_rt_addr_i = 5'd14;
    #1 check("busy_r14_set_wins", busy_o, 1);
    chk_rt_addr_i = '0;
    step();

    // Reset mid-operation with two LU entries queued and r5 reserved
    pipe_we_i = 1'b1; pipe_addr_i = 5'd2; pipe_data_i = 32'h1111;
    lu_valid_i = 1'b1; lu_addr_i = 5'd21; lu_data_i = 32'h2121;
    rsv_i = 1'b1; rsv_addr_i = 5'd5;
    expect_wr(5'd2, 32'h1111);
    step();
    pipe_data_i = 32'h2222; lu_addr_i = 5'd22; lu_data_i = 32'h2222;
    rsv_i = 1'b0; chk_rs_addr_i = 5'd5;
    step();
    check("pre_rst_ready_low", lu_ready_o, 0);
    check("pre_rst_busy_r5", busy_o, 1);
    #1;
    rst_i = 1'b0;
    pipe_we_i = 1'b0; lu_valid_i = 1'b0;
    #1;
    check("mid_rst_regwrite", RegWrite_o, 0);
    check("mid_rst_ready", lu_ready_o, 1);
    check("mid_rst_busy_r5", busy_o, 0);
    check("mid_rst_waw", waw_err_o, 0);
    check("mid_rst_rdaddr", RDaddr_o, 0);
    check("mid_rst_rddata", RDdata_o, 0);
    step(); step();
    rst_i = 1'b1;
    repeat (4) step();
    check("post_rst_idle", RegWrite_o, 0);
    check("post_rst_ready", lu_ready_o, 1);
    chk_rs_addr_i = '0;

    check("all_writes_seen", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
